// File: rtl/ins_fetch_queue_if.sv
// Fetch queue bus: program-memory instruction port plus decoder handshake.
// slave = the fetch queue, master = memory/decoder side.
interface ins_fetch_queue_if;
    logic [12:0] ins_adr_o;
    logic [15:0] ins_dat_i;
    logic        flush_i;
    logic [12:0] flush_adr_i;
    logic        ack_i;
    logic [15:0] inst_o;
    logic [12:0] inst_adr_o;
    logic        valid_o;

    modport slave (
        output ins_adr_o,
        input  ins_dat_i,
        input  flush_i,
        input  flush_adr_i,
        input  ack_i,
        output inst_o,
        output inst_adr_o,
        output valid_o
    );

    modport master (
        input  ins_adr_o,
        output ins_dat_i,
        output flush_i,
        output flush_adr_i,
        output ack_i,
        input  inst_o,
        input  inst_adr_o,
        input  valid_o
    );
endinterface

// File: rtl/ins_fetch_queue.sv
// Instruction prefetch queue: issues word fetches to a synchronous-read
// program memory, buffers returned words, hands them out with valid/ack.
module ins_fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [12:0] RESET_ADR = 13'h0000
) (
    input logic              ins_clk_i,
    input logic              ins_rst_n_i,
    ins_fetch_queue_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [12:0]   pc_q, pc_d;
    logic          pend_v_q, pend_v_d;
    logic [12:0]   pend_adr_q, pend_adr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   dat_q [DEPTH];
    logic [15:0]   dat_d [DEPTH];
    logic [12:0]   adr_q [DEPTH];
    logic [12:0]   adr_d [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Counting the in-flight fetch keeps a slot reserved for its data.
    assign issue = ~bus.flush_i
                 & ((cnt_q + {{AW{1'b0}}, pend_v_q}) < FULL);
    assign push  = pend_v_q & ~bus.flush_i;
    assign pop   = bus.ack_i & (cnt_q != '0) & ~bus.flush_i;

    always_comb begin
        pc_d       = pc_q;
        pend_v_d   = pend_v_q;
        pend_adr_d = pend_adr_q;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dat_d      = dat_q;
        adr_d      = adr_q;

        if (bus.flush_i) begin
            pc_d     = bus.flush_adr_i;
            pend_v_d = 1'b0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            pend_v_d = issue;
            if (issue) begin
                pend_adr_d = pc_q;
                pc_d       = pc_q + 13'd1;
            end
            if (push) begin
                dat_d[wr_ptr_q] = bus.ins_dat_i;
                adr_d[wr_ptr_q] = pend_adr_q;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge ins_clk_i or negedge ins_rst_n_i) begin
        if (!ins_rst_n_i) begin
            pc_q       <= RESET_ADR;
            pend_v_q   <= 1'b0;
            pend_adr_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dat_q[i] <= '0;
                adr_q[i] <= '0;
            end
        end else begin
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_adr_q <= pend_adr_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dat_q      <= dat_d;
            adr_q      <= adr_d;
        end
    end

    assign bus.ins_adr_o  = pc_q;
    assign bus.valid_o    = (cnt_q != '0);
    assign bus.inst_o     = dat_q[rd_ptr_q];
    assign bus.inst_adr_o = adr_q[rd_ptr_q];
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Random + directed bench for ins_fetch_queue: the expected instruction
// stream is sequential words from each restart address, scoreboarded.
module tb_ins_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [12:0] adr;
        logic [15:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ins_fetch_queue_if bus ();

    ins_fetch_queue #(
        .DEPTH     (DEPTH),
        .RESET_ADR (13'h0000)
    ) dut (
        .ins_clk_i   (clk),
        .ins_rst_n_i (rst_n),
        .bus         (bus)
    );

    logic [15:0] mem [8192];
    exp_t        sb[$];
    int          tests = 0;
    int          errors = 0;
    int          pops = 0;

    always @(posedge clk) bus.ins_dat_i <= mem[bus.ins_adr_o];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Restart point: everything older is void, stream restarts at start.
    task automatic expect_from(input logic [12:0] start, input int n);
        logic [12:0] a;
        sb.delete();
        for (int i = 0; i < n; i++) begin
            a = start + 13'(i);
            sb.push_back('{adr: a, dat: mem[a]});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.valid_o && bus.ack_i && !bus.flush_i) begin
            pops++;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(bus.inst_adr_o), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("stream_adr", 32'(bus.inst_adr_o), 32'(e.adr));
                chk("stream_dat", 32'(bus.inst_o), 32'(e.dat));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush(input logic [12:0] t, input logic ack);
        bus.flush_i     = 1'b1;
        bus.flush_adr_i = t;
        bus.ack_i       = ack;
        expect_from(t, 700);
        tick();
        bus.flush_i = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_adr", 32'(bus.ins_adr_o), 32'd0);
        chk("rst_inst", 32'(bus.inst_o), 32'd0);
        chk("rst_inst_adr", 32'(bus.inst_adr_o), 32'd0);
        expect_from(13'h0000, 700);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [12:0] t;
        int p0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'h1000 + 16'(i);
        bus.flush_i     = 1'b0;
        bus.flush_adr_i = '0;
        bus.ack_i       = 1'b1;

        // Scenario 1: reset release, ack held, valid two clocks later
        async_reset();
        tick();
        chk("s1_valid_clk1", 32'(bus.valid_o), 32'd0);
        tick();
        chk("s1_valid_clk2", 32'(bus.valid_o), 32'd1);
        chk("s1_first_adr", 32'(bus.inst_adr_o), 32'd0);
        chk("s1_first_dat", 32'(bus.inst_o), 32'h1000);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("s1_no_gap", 32'(bus.valid_o), 32'd1);
        end

        // Scenario 2: no ack fills the queue, then drain without bubble
        bus.ack_i = 1'b0;
        async_reset();
        for (int i = 0; i < 8; i++) tick();
        chk("s2_pc_hold", 32'(bus.ins_adr_o), 32'h0004);
        chk("s2_valid", 32'(bus.valid_o), 32'd1);
        chk("s2_head_dat", 32'(bus.inst_o), 32'h1000);
        tick();
        chk("s2_pc_hold2", 32'(bus.ins_adr_o), 32'h0004);
        bus.ack_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s2_drain_gap", 32'(bus.valid_o), 32'd1);
        end

        // Scenario 3: flush with data in flight and a same-cycle ack
        bus.ack_i = 1'b0;
        tick();
        tick();
        do_flush(13'h0123, 1'b1);
        chk("s3_pc", 32'(bus.ins_adr_o), 32'h0123);
        chk("s3_valid_f1", 32'(bus.valid_o), 32'd0);
        tick();
        chk("s3_valid_f2", 32'(bus.valid_o), 32'd0);
        tick();
        chk("s3_valid_f3", 32'(bus.valid_o), 32'd1);
        chk("s3_adr", 32'(bus.inst_adr_o), 32'h0123);
        for (int i = 0; i < 10; i++) tick();

        // Scenario 4: address wrap 1FFF -> 0000
        do_flush(13'h1FFE, 1'b1);
        tick();
        tick();
        chk("s4_adr", 32'(bus.inst_adr_o), 32'h1FFE);
        for (int i = 0; i < 6; i++) tick();

        // Scenario 5: random memory, toggling ack for 500 clocks
        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        t = 13'($urandom);
        do_flush(t, 1'b0);
        p0 = pops;
        for (int i = 0; i < 500; i++) begin
            bus.ack_i = ~bus.ack_i;
            tick();
        end
        chk("s5_throughput", 32'(pops - p0 >= 240), 32'd1);

        // Random ack with occasional random redirects
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_flush(13'($urandom), 1'($urandom));
            end else begin
                bus.ack_i = 1'($urandom);
                tick();
            end
        end

        // Scenario 6: asynchronous reset mid-stream, then restart
        bus.ack_i = 1'b1;
        async_reset();
        tick();
        chk("s6_valid_clk1", 32'(bus.valid_o), 32'd0);
        tick();
        chk("s6_valid_clk2", 32'(bus.valid_o), 32'd1);
        chk("s6_first_adr", 32'(bus.inst_adr_o), 32'd0);
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
